// File: rtl/ccg_sig_harness.sv
// ============================================================================
// Module   : ccg_sig_harness
// Purpose  : Exhaustive stimulus driver and MISR response compactor for one
//            combinational netlist; reports signature match against exp_sig.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ccg_sig_harness #(
    parameter int                N_IN      = 5,
    parameter int                N_OUT     = 10,
    parameter int                MISR_W    = 16,
    parameter logic [MISR_W-1:0] MISR_POLY = 16'h1021,
    parameter logic [MISR_W-1:0] MISR_SEED = 16'hFFFF,
    parameter int                SETTLE    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [MISR_W-1:0] exp_sig,
    output logic [N_IN-1:0]   x_out,
    input  logic [N_OUT-1:0]  f_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [MISR_W-1:0] sig
);

    localparam int                SET_W       = $clog2(SETTLE + 1);
    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE - 1);
    localparam logic [N_IN:0]     LAST_PAT    = {1'b0, {N_IN{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [N_IN:0]       pat_cnt;
    logic [SET_W-1:0]    settle_cnt;
    logic [MISR_W-1:0]   exp_lat;
    logic [MISR_W-1:0]   sig_next;
    logic                last_pat;
    logic                settle_end;

    // Extra counter bit keeps the last-pattern test a compare, never a wrap.
    assign x_out      = pat_cnt[N_IN-1:0];
    assign last_pat   = (pat_cnt == LAST_PAT);
    assign settle_end = (settle_cnt == SETTLE_LAST);
    assign sig_next   = {sig[MISR_W-2:0], 1'b0}
                      ^ (sig[MISR_W-1] ? MISR_POLY : '0)
                      ^ MISR_W'(f_in);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (start) next_state = S_WAIT;
            S_WAIT:    if (settle_end) next_state = S_CAPTURE;
            S_CAPTURE: next_state = last_pat ? S_DONE : S_WAIT;
            S_DONE:    next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_cnt    <= '0;
            settle_cnt <= '0;
            exp_lat    <= '0;
            sig        <= MISR_SEED;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        exp_lat    <= exp_sig;
                        sig        <= MISR_SEED;
                        pat_cnt    <= '0;
                        settle_cnt <= '0;
                        pass       <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (!settle_end) settle_cnt <= settle_cnt + 1'b1;
                end
                S_CAPTURE: begin
                    sig <= sig_next;
                    if (last_pat) begin
                        // Verdict is registered alongside done so both are valid together.
                        busy <= 1'b0;
                        done <= 1'b1;
                        pass <= (sig_next == exp_lat);
                    end else begin
                        pat_cnt    <= pat_cnt + 1'b1;
                        settle_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ccg_sig_harness.sv
// ============================================================================
// Module   : tb_ccg_sig_harness
// Purpose  : Directed self-checking bench for ccg_sig_harness.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ccg_sig_harness;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Default instance, loopback netlist model
    logic        start0 = 1'b0;
    logic [15:0] exp0   = '0;
    logic [4:0]  x0;
    logic        busy0, done0, pass0;
    logic [15:0] sig0;
    wire  [9:0]  f0 = {5'b0, x0};

    ccg_sig_harness dut0 (
        .clk(clk), .rst(rst), .start(start0), .exp_sig(exp0), .x_out(x0),
        .f_in(f0), .busy(busy0), .done(done0), .pass(pass0), .sig(sig0)
    );

    // One input, zero seed, response tied to 1
    logic        start1 = 1'b0;
    logic [15:0] exp1   = 16'h0003;
    logic [0:0]  x1;
    logic        busy1, done1, pass1;
    logic [15:0] sig1;

    ccg_sig_harness #(.N_IN(1), .MISR_SEED(16'h0000)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .exp_sig(exp1), .x_out(x1),
        .f_in(10'd1), .busy(busy1), .done(done1), .pass(pass1), .sig(sig1)
    );

    // One input, seed 8000, response tied to 0
    logic        start2 = 1'b0;
    logic [15:0] exp2   = '0;
    logic [0:0]  x2;
    logic        busy2, done2, pass2;
    logic [15:0] sig2;

    ccg_sig_harness #(.N_IN(1), .MISR_SEED(16'h8000)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .exp_sig(exp2), .x_out(x2),
        .f_in(10'd0), .busy(busy2), .done(done2), .pass(pass2), .sig(sig2)
    );

    // SETTLE=3, response is junk for two cycles after each pattern change
    logic        start3 = 1'b0;
    logic [15:0] exp3   = '0;
    logic [4:0]  x3;
    logic        busy3, done3, pass3;
    logic [15:0] sig3;
    logic [4:0]  last_x3 = '0;
    int          age3 = 100;
    logic [9:0]  junk = '0;
    wire  [9:0]  f3 = (age3 < 2) ? junk : {5'b0, x3};

    always @(negedge clk) begin
        if (x3 !== last_x3) begin
            last_x3 <= x3;
            age3    <= 0;
        end else begin
            age3 <= age3 + 1;
        end
        junk <= 10'($urandom);
    end

    ccg_sig_harness #(.SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .exp_sig(exp3), .x_out(x3),
        .f_in(f3), .busy(busy3), .done(done3), .pass(pass3), .sig(sig3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [15:0] f);
        logic [15:0] r;
        r = {s[14:0], 1'b0} ^ f;
        if (s[15]) r = r ^ 16'h1021;
        return r;
    endfunction

    typedef struct {
        logic        start;
        logic        busy;
        logic        done;
        logic [0:0]  x;
        logic [15:0] sig;
        logic        pass;
    } vec_t;

    typedef struct {
        logic [15:0] exp_in;
        logic [15:0] sig;
        logic        pass;
    } run_t;

    logic [15:0] model_sig;

    // Full-length run on dut0 (which=0) or dut3 (which=3), with a mid-run
    // start and a start on the DONE cycle, both of which must be ignored.
    task automatic run_full(input int which, input int per, input int total, input string tag);
        int busy_cnt = 0;
        int done_cnt = 0;
        int xbad = 0;
        bit seen_done = 0;
        logic b, d, p;
        logic [4:0]  x;
        logic [15:0] s;
        if (which == 0) start0 = 1'b1; else start3 = 1'b1;
        @(negedge clk);
        if (which == 0) start0 = 1'b0; else start3 = 1'b0;
        for (int c = 0; c < 400; c++) begin
            b = (which == 0) ? busy0 : busy3;
            d = (which == 0) ? done0 : done3;
            p = (which == 0) ? pass0 : pass3;
            x = (which == 0) ? x0 : x3;
            s = (which == 0) ? sig0 : sig3;
            if (b) begin
                if (x !== 5'(busy_cnt / per)) xbad++;
                busy_cnt++;
            end
            if (d) begin
                done_cnt++;
                if (!seen_done) begin
                    check({tag, "_sig"}, 32'(s), 32'(model_sig));
                    check({tag, "_pass"}, 32'(p), 32'd1);
                end
                seen_done = 1;
            end
            if (seen_done && !d) break;
            if (which == 0) start0 = (c == 10) || d; else start3 = (c == 10) || d;
            @(negedge clk);
        end
        start0 = 1'b0;
        start3 = 1'b0;
        check({tag, "_finished"}, 32'(seen_done), 32'd1);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(total));
        check({tag, "_done_cycles"}, 32'(done_cnt), 32'd1);
        check({tag, "_x_steps_bad"}, 32'(xbad), 32'd0);
        repeat (3) @(negedge clk);
        b = (which == 0) ? busy0 : busy3;
        x = (which == 0) ? x0 : x3;
        s = (which == 0) ? sig0 : sig3;
        check({tag, "_no_restart"}, 32'(b), 32'd0);
        check({tag, "_x_held"}, 32'(x), 32'd31);
        check({tag, "_sig_held"}, 32'(s), 32'(model_sig));
    endtask

    initial begin
        vec_t tbl[8];
        run_t runs[2];
        bit   found;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h0003, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b1};

        runs[0] = '{16'h2042, 16'h2042, 1'b1};
        runs[1] = '{16'h2043, 16'h2042, 1'b0};

        model_sig = 16'hFFFF;
        for (int p = 0; p < 32; p++) model_sig = misr_step(model_sig, 16'(p));
        exp0 = model_sig;
        exp3 = model_sig;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_sig0",  32'(sig0),  32'hFFFF);
        check("rst_x0",    32'(x0),    32'd0);
        check("rst_busy0", 32'(busy0), 32'd0);
        check("rst_done0", 32'(done0), 32'd0);
        check("rst_pass0", 32'(pass0), 32'd0);
        check("rst_sig1",  32'(sig1),  32'h0000);
        check("rst_sig2",  32'(sig2),  32'h8000);

        // Asynchronous reset while pattern 7 is settling
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        found = 0;
        for (int c = 0; c < 100; c++) begin
            if (x0 == 5'h07) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("t1_reached_x7", 32'(found), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t1_x",    32'(x0),    32'd0);
        check("t1_sig",  32'(sig0),  32'hFFFF);
        check("t1_busy", 32'(busy0), 32'd0);
        check("t1_done", 32'(done0), 32'd0);
        check("t1_pass", 32'(pass0), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_full(0, 2, 64, "t4");
        run_full(3, 4, 128, "t6");

        // Cycle-accurate trace of the one-input harness
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t2_busy[%0d]", i), 32'(busy1), 32'(tbl[i].busy));
            check($sformatf("t2_done[%0d]", i), 32'(done1), 32'(tbl[i].done));
            check($sformatf("t2_x[%0d]", i),    32'(x1),    32'(tbl[i].x));
            check($sformatf("t2_sig[%0d]", i),  32'(sig1),  32'(tbl[i].sig));
            check($sformatf("t2_pass[%0d]", i), 32'(pass1), 32'(tbl[i].pass));
            start1 = tbl[i].start;
            @(negedge clk);
        end
        start1 = 1'b0;

        for (int i = 0; i < 2; i++) begin
            exp2   = runs[i].exp_in;
            start2 = 1'b1;
            @(negedge clk);
            start2 = 1'b0;
            repeat (2) @(negedge clk);
            check($sformatf("t3_sig_p0[%0d]", i), 32'(sig2), 32'h1021);
            found = 0;
            for (int c = 0; c < 10; c++) begin
                if (done2) begin
                    found = 1;
                    break;
                end
                @(negedge clk);
            end
            check($sformatf("t3_done[%0d]", i), 32'(found), 32'd1);
            check($sformatf("t3_sig[%0d]", i),  32'(sig2),  32'(runs[i].sig));
            check($sformatf("t3_pass[%0d]", i), 32'(pass2), 32'(runs[i].pass));
            repeat (2) @(negedge clk);
            check($sformatf("t3_pass_hold[%0d]", i), 32'(pass2), 32'(runs[i].pass));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
